// File: rtl/microcore_sequencer.sv
// Feed/control end of the SHA-256 microcore array: accepts work, broadcasts the
// lock-step round drive to all cores and converts golden flags into absolute nonces.
module microcore_sequencer #(
  parameter int NUM_CORES = 8,
  parameter int CNT_MAX   = 67,
  parameter int IDX_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 work_valid,
  output logic                 work_ready,
  input  logic [255:0]         work_midstate,
  input  logic [31:0]          work_m7,
  input  logic [95:0]          work_data,
  output logic [7:0]           cnt,
  output logic                 pass,
  output logic [31:0]          k_in,
  output logic [31:0]          r1_in,
  output logic [255:0]         midstate,
  output logic [31:0]          m7,
  input  logic [NUM_CORES-1:0] gnon,
  output logic                 nonce_valid,
  input  logic                 nonce_ready,
  output logic [31:0]          nonce,
  output logic                 overflow,
  output logic                 exhausted
);
  localparam logic [7:0]  CNT_LAST  = 8'(CNT_MAX);
  localparam logic [32:0] CORE_STEP = 33'(NUM_CORES);
  localparam logic [31:0] K256 [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_n;
  logic [95:0]      data, data_n;
  logic [31:0]      base, base_n, prev_base, prev_base_n;
  logic [32:0]      base_sum;
  logic [7:0]       cnt_n;
  logic             pass_n;
  logic             boundary, accept, wrap, skip_hit, capture;
  logic [IDX_W-1:0] hit_idx;
  logic [31:0]      candidate;

  function automatic logic [31:0] k_lookup(input logic [7:0] c);
    return (c < 8'd64) ? K256[c[5:0]] : 32'h0;
  endfunction

  function automatic logic [31:0] r1_sched(input logic p, input logic [7:0] c,
                                           input logic [31:0] b, input logic [95:0] d);
    logic [31:0] r;
    r = 32'h0;
    if (!p) begin
      case (c)
        8'd0:    r = d[31:0];
        8'd1:    r = d[63:32];
        8'd2:    r = d[95:64];
        8'd3:    r = b;
        8'd4:    r = 32'h80000000;
        8'd15:   r = 32'h00000280;
        default: r = 32'h0;
      endcase
    end else begin
      case (c)
        8'd8:    r = 32'h80000000;
        8'd15:   r = 32'h00000100;
        default: r = 32'h0;
      endcase
    end
    return r;
  endfunction

  assign boundary = (state == RUN) && pass && (cnt == CNT_LAST);
  assign base_sum = {1'b0, base} + CORE_STEP;
  assign accept   = work_ready;
  assign data_n   = accept ? work_data : data;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pass_n      = pass;
    base_n      = base;
    prev_base_n = prev_base;
    work_ready  = 1'b0;
    wrap        = 1'b0;
    case (state)
      IDLE: begin
        work_ready = work_valid;
        if (work_valid) begin
          state_n = RUN;
          base_n  = 32'h0;
        end
      end
      RUN: begin
        if (cnt == CNT_LAST) begin
          cnt_n  = 8'h0;
          pass_n = ~pass;
        end else begin
          cnt_n = cnt + 8'h1;
        end
        // New work only joins at a batch boundary, so cores never see a mixed batch.
        if (boundary) begin
          work_ready  = work_valid;
          prev_base_n = base;
          if (work_valid) begin
            base_n = 32'h0;
          end else if (base_sum[32]) begin
            wrap    = 1'b1;
            state_n = IDLE;
            cnt_n   = 8'h0;
            pass_n  = 1'b0;
            base_n  = base_sum[31:0];
          end else begin
            base_n = base_sum[31:0];
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Lowest-numbered core wins when several report a hit together.
  always_comb begin
    hit_idx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (gnon[i]) hit_idx = IDX_W'(i);
    end
  end

  assign candidate = prev_base + 32'(hit_idx);
  assign capture   = (state == RUN) && !pass && (cnt == 8'd1) && !skip_hit && (|gnon);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 8'h0;
      pass        <= 1'b0;
      k_in        <= 32'h0;
      r1_in       <= 32'h0;
      midstate    <= 256'h0;
      m7          <= 32'h0;
      data        <= 96'h0;
      base        <= 32'h0;
      prev_base   <= 32'h0;
      skip_hit    <= 1'b0;
      nonce_valid <= 1'b0;
      nonce       <= 32'h0;
      overflow    <= 1'b0;
      exhausted   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      pass      <= pass_n;
      base      <= base_n;
      prev_base <= prev_base_n;
      exhausted <= wrap;
      data      <= data_n;
      if (accept) begin
        midstate <= work_midstate;
        m7       <= work_m7;
      end
      // Drive words are computed from next-cycle cnt/pass so all outputs line up.
      if (state_n == RUN) begin
        k_in  <= k_lookup(cnt_n);
        r1_in <= r1_sched(pass_n, cnt_n, base_n, data_n);
      end else begin
        k_in  <= 32'h0;
        r1_in <= 32'h0;
      end
      if (state == IDLE && accept) begin
        skip_hit <= 1'b1;
      end else if (state == RUN && !pass && cnt == 8'd1) begin
        skip_hit <= 1'b0;
      end
      if (capture) begin
        if (!nonce_valid || nonce_ready) begin
          nonce       <= candidate;
          nonce_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (nonce_valid && nonce_ready) begin
        nonce_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/microcore_sequencer.md
Name: microcore_sequencer

Overview:
- Control and feed end of the SHA-256 microcore array.
- Accepts work (midstate, m7, 96-bit header tail) over a valid/ready handshake and broadcasts the shared drive to all NUM_CORES cores: cnt, pass, k_in, r1_in, midstate, m7.
- Each core receives message words, round constants and the nonce base in lock-step.
- Collects the per-core gnon flags, converts a hit into an absolute nonce, and presents it on a valid/ready output.

Parameters:
- NUM_CORES, 8: cores sharing the drive. Core N adds N to the nonce base internally.
- CNT_MAX, 67: last cnt value of a pass. cnt runs 0..CNT_MAX.
- IDX_W, 3: width of the hit core index. Must satisfy 2^IDX_W >= NUM_CORES.

Ports:
- clk, in, 1: single clock.
- rst_n, in, 1: asynchronous active-low reset.
- work_valid, in, 1: new work available.
- work_ready, out, 1: work accepted this cycle.
- work_midstate, in, 256: midstate for the new work.
- work_m7, in, 32: m7 constant for the new work.
- work_data, in, 96: header tail. Bits [31:0]=word0, [63:32]=word1, [95:64]=word2.
- cnt, out, 8: round counter to cores.
- pass, out, 1: 0 = first hash, 1 = second hash.
- k_in, out, 32: round constant.
- r1_in, out, 32: message word.
- midstate, out, 256: latched work midstate.
- m7, out, 32: latched work m7.
- gnon, in, NUM_CORES: bit i is the golden flag from core i.
- nonce_valid, out, 1: golden nonce pending.
- nonce_ready, in, 1: consumer takes the nonce.
- nonce, out, 32: golden nonce.
- overflow, out, 1: sticky; a hit was dropped.
- exhausted, out, 1: one-cycle pulse when the nonce space wraps.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - cnt=0, pass=0, k_in=0, r1_in=0, midstate=0, m7=0.
  - nonce_valid=0, nonce=0, overflow=0, exhausted=0, work_ready=0.
  - Internal base=0, prev_base=0.
  - Reset during RUN aborts the batch immediately. No pending nonce survives.
- State IDLE:
  - cnt and pass held at 0.
  - work_ready = work_valid (combinational).
  - On accept: latch midstate, m7 and data; set base=0; next cycle enters RUN with cnt=0, pass=0.
- State RUN:
  - cnt increments by 1 every cycle.
  - At cnt==CNT_MAX: cnt wraps to 0 and pass toggles.
  - At pass 1->0 (batch boundary): prev_base<=base and base<=base+NUM_CORES (32-bit).
  - Also at the batch boundary, work_ready=work_valid. If accepted, new work is latched, base<=0 and prev_base<=old base; RUN continues without a bubble. Work is never accepted mid-batch.
  - If base+NUM_CORES carries out of 32 bits and no work is accepted at that boundary: pulse exhausted and go to IDLE (cnt=0, pass=0).
- Output registration:
  - All core-drive outputs are registered and mutually consistent for the cnt value being presented.
  - k_in = K256[cnt] for cnt<64, else 0.
- r1_in schedule, pass 0 (indexed by presented cnt):
  - 0, 1, 2 -> word0, word1, word2.
  - 3 -> base.
  - 4 -> 32'h80000000.
  - 5..14 -> 0.
  - 15 -> 32'h00000280.
  - 16..CNT_MAX -> 0 (don't care to cores).
- r1_in schedule, pass 1:
  - 0..7 -> 0 (cores source these internally).
  - 8 -> 32'h80000000.
  - 9..14 -> 0.
  - 15 -> 32'h00000100.
  - Remainder -> 0.
- Hit capture:
  - gnon is sampled only in the cycle where the presented cnt==1 and pass==0. Its value refers to the batch that just finished, so the nonce is built from prev_base.
  - Any gnon bit set: idx = lowest set bit; candidate = prev_base + idx.
  - gnon is ignored in all other cycles and in IDLE, except the first cnt==1 after work is accepted from IDLE, which is also ignored because no previous batch exists.
- Output register (depth 1):
  - If nonce_valid==0, or nonce_valid && nonce_ready in the same cycle: load candidate and set nonce_valid=1.
  - Otherwise drop the candidate and set overflow=1. overflow clears only on reset.
  - nonce_valid && nonce_ready with no new hit clears nonce_valid.
  - nonce is held stable while nonce_valid=1 and nonce_ready=0.

Test Plan:
- Reset then idle: hold rst_n=0 5 cycles, work_valid=0 -> all outputs 0; after release cnt stays 0 and work_ready=0.
- Load work: midstate=256'h01..20, m7=32'hDEADBEEF, data={32'h3,32'h2,32'h1} -> at pass0 cnt 0..4, r1_in = 1, 2, 3, 0, 80000000; cnt15 r1_in=00000280; k_in at cnt0=428A2F98 and at cnt63=C67178F2; at cnt==67, pass toggles and cnt returns to 0.
- Nonce progression: run 3 batches with NUM_CORES=8 -> r1_in at pass0 cnt3 = 0, 8, 16.
- Hit mapping: gnon=8'b00100100 at second batch, pass0 cnt1 -> nonce_valid=1, nonce=32'h00000002.
- Backpressure: hits in two consecutive batches with nonce_ready=0 -> first nonce held, overflow=1; with nonce_ready=1 in the capture cycle -> second nonce loaded and no overflow.
- Wrap and mid-run reset: preload base=32'hFFFFFFF8 -> exhausted pulses once, IDLE entered; separately, asserting rst_n=0 at cnt=30 -> cnt=0, nonce_valid=0 asynchronously.
